riscv32ima_issue_ctrl: RTL

RISCV32IMA_ISSUE_CTRL -- requirements
Module: riscv32ima_issue_ctrl

---
 rtl/riscv32ima_issue_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/riscv32ima_issue_ctrl.sv
// Issue control: register scoreboard with clear bypass and
// redirect drain/refill sequencing in front of the ALU.
module riscv32ima_issue_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REFILL_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [REG_ADDR_WIDTH-1:0] dec_src0_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_src1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_dst_addr,
  input  logic                      dec_uses_src0,
  input  logic                      dec_uses_src1,
  input  logic                      dec_writes_dst,
  output logic                      alu_issue_valid,
  input  logic                      alu_issue_ready,
  input  logic                      wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  input  logic                      squash_valid,
  input  logic [REG_ADDR_WIDTH-1:0] squash_addr,
  input  logic                      wback_pc_wen,
  output logic                      hazard,
  output logic [REG_ADDR_WIDTH:0]   pending_cnt,
  output logic [1:0]                state
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    REFILL = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              refill_q, refill_d;
  logic [NREG-1:0]         sb_q, sb_d;
  logic [NREG-1:0]         clr, set, busy;
  logic [REG_ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                    dst_nz, run, fire;

  always_comb begin
    clr = '0;
    if (wback_reg_wen) clr[wback_reg_addr] = 1'b1;
    if (squash_valid)  clr[squash_addr]    = 1'b1;
  end

  // bits being cleared this cycle no longer block the decoder
  assign busy   = sb_q & ~clr;
  assign dst_nz = |dec_dst_addr;

  assign hazard = dec_valid &
    ((dec_uses_src0 & busy[dec_src0_addr]) |
     (dec_uses_src1 & busy[dec_src1_addr]) |
     (dec_writes_dst & dst_nz & busy[dec_dst_addr]));

  assign run = nrst & (state_q == RUN);

  assign alu_issue_valid = dec_valid & run & ~hazard
                         & ~wback_pc_wen;
  assign dec_ready = run & ~hazard & ~wback_pc_wen
                   & alu_issue_ready;
  assign fire = dec_valid & dec_ready;

  always_comb begin
    set = '0;
    if (fire && dec_writes_dst && dst_nz)
      set[dec_dst_addr] = 1'b1;
  end

  always_comb begin
    sb_d    = busy | set;
    sb_d[0] = 1'b0;
    cnt_d   = '0;
    for (int i = 0; i < NREG; i++)
      cnt_d = cnt_d + {{REG_ADDR_WIDTH{1'b0}}, sb_d[i]};
  end

  always_comb begin
    state_d  = state_q;
    refill_d = refill_q;
    unique case (state_q)
      RUN: begin
        if (wback_pc_wen) state_d = DRAIN;
      end
      DRAIN: begin
        if (!wback_pc_wen && cnt_q == '0 && set == '0) begin
          state_d  = REFILL;
          refill_d = 4'(REFILL_CYCLES);
        end
      end
      REFILL: begin
        if (wback_pc_wen) begin
          state_d = DRAIN;
        end else begin
          refill_d = refill_q - 4'd1;
          if (refill_q == 4'd1) state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        refill_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= RUN;
      refill_q <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;
  assign state       = state_q;

endmodule
